// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    A_IDLE,
    A_GNT0,
    A_GNT1,
    A_ABORT
  } arb_state_t;

  localparam int M0 = 0;
  localparam int M1 = 1;

  function automatic logic [1:0] onehot(input int idx);
    return (idx == M0) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bus bundle; dat_m flows master->slave, dat_s flows slave->master.
interface if_wb #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [AWIDTH-1:0]     adr;
  logic [DWIDTH/8-1:0]   sel;
  logic [DWIDTH-1:0]     dat_m;
  logic [DWIDTH-1:0]     dat_s;
  logic                  ack;
  logic                  stall;

  modport master (output cyc, stb, we, adr, sel, dat_m, input dat_s, ack, stall);
  modport slave  (input cyc, stb, we, adr, sel, dat_m, output dat_s, ack, stall);
endinterface

// File: rtl/wb_watchdog.sv
// Hang detector: counts enabled cycles since the last clear and pulses expire on the
// cycle the count reaches TIMEOUT-1 without a clear.
module wb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // A clear (an ack) in the final cycle overrides expiry.
  assign expire_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter: round-robin, grant locked for a whole
// cyc, one idle turnaround cycle between owners, hang watchdog and per-master ack counters.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int TIMEOUT  = 1024,
  parameter int CNTWIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  if_wb.slave                 m0,
  if_wb.slave                 m1,
  if_wb.master                mem,
  output logic [1:0]          grant,
  output logic                timeout,
  output logic [CNTWIDTH-1:0] ackcnt0,
  output logic [CNTWIDTH-1:0] ackcnt1
);

  arb_state_t          state_q;
  logic                last_q;
  logic [1:0]          grant_q;
  logic [CNTWIDTH-1:0] ackCnt0_q;
  logic [CNTWIDTH-1:0] ackCnt1_q;

  logic [DWIDTH-1:0]   m0DatM;
  logic [DWIDTH-1:0]   m1DatM;
  logic [DWIDTH-1:0]   memDatS;
  logic [DWIDTH-1:0]   memDatM;
  logic [DWIDTH-1:0]   m0DatS;
  logic [DWIDTH-1:0]   m1DatS;
  logic [AWIDTH-1:0]   memAdr;
  logic [DWIDTH/8-1:0] memSel;
  logic                memCyc, memStb, memWe;
  logic                m0Stall, m0Ack, m1Stall, m1Ack;
  logic                granted, ownerCyc, wdogClr, expire;

  assign m0DatM  = m0.dat_m;
  assign m1DatM  = m1.dat_m;
  assign memDatS = mem.dat_s;

  assign granted  = (state_q == A_GNT0) || (state_q == A_GNT1);
  assign ownerCyc = grant_q[M1] ? m1.cyc : m0.cyc;
  assign wdogClr  = ~granted | mem.ack;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) uWdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wdogClr),
    .en_i     (granted),
    .expire_o (expire)
  );

  // Arbitration FSM; last_q names the previous owner so a tie goes to the other master.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= A_IDLE;
      last_q    <= 1'b1;
      grant_q   <= 2'b00;
      ackCnt0_q <= '0;
      ackCnt1_q <= '0;
    end else begin
      if (state_q == A_GNT0 && mem.ack)
        ackCnt0_q <= ackCnt0_q + CNTWIDTH'(1);
      if (state_q == A_GNT1 && mem.ack)
        ackCnt1_q <= ackCnt1_q + CNTWIDTH'(1);
      unique case (state_q)
        A_IDLE: begin
          if (m0.cyc && (!m1.cyc || last_q)) begin
            state_q <= A_GNT0;
            grant_q <= onehot(M0);
            last_q  <= 1'b0;
          end else if (m1.cyc) begin
            state_q <= A_GNT1;
            grant_q <= onehot(M1);
            last_q  <= 1'b1;
          end
        end
        A_GNT0, A_GNT1: begin
          if (!ownerCyc) begin
            state_q <= A_IDLE;
            grant_q <= 2'b00;
          end else if (expire) begin
            state_q <= A_ABORT;
          end
        end
        A_ABORT: begin
          if (!ownerCyc) begin
            state_q <= A_IDLE;
            grant_q <= 2'b00;
          end
        end
      endcase
    end
  end

  // Owner is wired straight through; everyone else sees stall and no ack.
  always_comb begin
    memCyc  = 1'b0;
    memStb  = 1'b0;
    memWe   = 1'b0;
    memAdr  = '0;
    memSel  = '0;
    memDatM = '0;
    m0Stall = 1'b1;
    m0Ack   = 1'b0;
    m0DatS  = '0;
    m1Stall = 1'b1;
    m1Ack   = 1'b0;
    m1DatS  = '0;
    unique case (state_q)
      A_GNT0: begin
        memCyc  = m0.cyc;
        memStb  = m0.stb;
        memWe   = m0.we;
        memAdr  = m0.adr;
        memSel  = m0.sel;
        memDatM = m0DatM;
        m0Stall = mem.stall;
        m0Ack   = mem.ack;
        m0DatS  = memDatS;
      end
      A_GNT1: begin
        memCyc  = m1.cyc;
        memStb  = m1.stb;
        memWe   = m1.we;
        memAdr  = m1.adr;
        memSel  = m1.sel;
        memDatM = m1DatM;
        m1Stall = mem.stall;
        m1Ack   = mem.ack;
        m1DatS  = memDatS;
      end
      default: ;
    endcase
  end

  assign mem.cyc   = memCyc;
  assign mem.stb   = memStb;
  assign mem.we    = memWe;
  assign mem.adr   = memAdr;
  assign mem.sel   = memSel;
  assign mem.dat_m = memDatM;
  assign m0.stall  = m0Stall;
  assign m0.ack    = m0Ack;
  assign m0.dat_s  = m0DatS;
  assign m1.stall  = m1Stall;
  assign m1.ack    = m1Ack;
  assign m1.dat_s  = m1DatS;

  assign grant   = grant_q;
  assign timeout = expire;
  assign ackcnt0 = ackCnt0_q;
  assign ackcnt1 = ackCnt1_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: two scripted masters and a 1-cycle-ack slave model.
module tb_wb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  grant;
  logic        timeout;
  logic [31:0] ackcnt0, ackcnt1;

  int total = 0;
  int bad = 0;
  int timeoutCnt = 0;
  int m1StallViol = 0;
  int adrViol = 0;
  int slaveBeats = 0;
  bit chkM1Stall = 0;
  bit slaveAckEn = 1;
  bit injectAck = 0;
  logic [31:0] lastWr = '0;
  logic [31:0] rd;
  int beatsBefore;

  if_wb #(.AWIDTH(32), .DWIDTH(32)) m0If ();
  if_wb #(.AWIDTH(32), .DWIDTH(32)) m1If ();
  if_wb #(.AWIDTH(32), .DWIDTH(32)) memIf ();

  wb_mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(8), .CNTWIDTH(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .m0      (m0If),
    .m1      (m1If),
    .mem     (memIf),
    .grant   (grant),
    .timeout (timeout),
    .ackcnt0 (ackcnt0),
    .ackcnt1 (ackcnt1)
  );

  always #5 clk_i = ~clk_i;

  // Slave: acks every accepted beat one cycle later, read data = adr + 0x1000_0000.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      memIf.ack   <= 1'b0;
      memIf.dat_s <= '0;
    end else begin
      memIf.ack   <= (slaveAckEn && memIf.cyc && memIf.stb && !memIf.stall) || injectAck;
      memIf.dat_s <= memIf.adr + 32'h1000_0000;
      if (memIf.cyc && memIf.stb && !memIf.stall) begin
        slaveBeats <= slaveBeats + 1;
        if (memIf.we) lastWr <= memIf.dat_m;
      end
    end
  end

  // Bus monitors; m1 lives at 0x2000 (adr[13]=1), m0 below it.
  always @(negedge clk_i) begin
    if (timeout === 1'b1) timeoutCnt++;
    if (chkM1Stall && m1If.stall !== 1'b1) m1StallViol++;
    if (memIf.cyc && memIf.stb &&
        ((grant == 2'b10 && !memIf.adr[13]) || (grant == 2'b01 && memIf.adr[13])))
      adrViol++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic setM(input int m, input logic cyc, input logic stb, input logic we,
                      input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0If.cyc = cyc; m0If.stb = stb; m0If.we = we; m0If.adr = adr; m0If.dat_m = dat; m0If.sel = 4'hf;
    end else begin
      m1If.cyc = cyc; m1If.stb = stb; m1If.we = we; m1If.adr = adr; m1If.dat_m = dat; m1If.sel = 4'hf;
    end
  endtask

  function automatic logic mStall(input int m);
    return (m == 0) ? m0If.stall : m1If.stall;
  endfunction

  function automatic logic mAck(input int m);
    return (m == 0) ? m0If.ack : m1If.ack;
  endfunction

  function automatic logic [31:0] mDatS(input int m);
    return (m == 0) ? m0If.dat_s : m1If.dat_s;
  endfunction

  // Pipelined n-beat burst by master m; optional 3-cycle slave stall and a mid-burst
  // request from the other master. Drops cyc after the last ack.
  task automatic applyStimulus(input int m, input logic [31:0] base, input logic we, input int n,
                               input int stallAt, input int raiseAt, output logic [31:0] lastRd);
    int issued, acks, cycles, stallLeft;
    bit stallUsed, raised, accept, stbNow;
    issued = 0; acks = 0; cycles = 0; stallLeft = 0;
    stallUsed = 0; raised = 0; stbNow = 1; lastRd = '0;
    setM(m, 1, 1, we, base, 32'hdeadbeef);
    while (acks < n && cycles < 64) begin
      if (stallAt >= 0 && !stallUsed && issued == stallAt) begin
        stallLeft = 3;
        stallUsed = 1;
      end
      memIf.stall = (stallLeft > 0);
      if (stallLeft > 0) stallLeft--;
      #1;
      if (stallAt >= 0) checkOutput("stall_mirror", mStall(m), memIf.stall);
      accept = stbNow && !mStall(m);
      tick;
      cycles++;
      if (accept) begin
        issued++;
        if (issued < n)
          setM(m, 1, 1, we, base + 32'(4 * issued), 32'hdeadbeef + 32'(issued));
        else begin
          stbNow = 0;
          setM(m, 1, 0, we, base, 32'h0);
        end
      end
      if (mAck(m)) begin
        acks++;
        lastRd = mDatS(m);
      end
      if (raiseAt >= 0 && !raised && acks >= raiseAt) begin
        raised = 1;
        setM(1 - m, 1, 1, 0, (m == 0) ? 32'h2000 : 32'h140, 32'h0);
      end
    end
    checkOutput("burst_acks", acks, n);
    setM(m, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    setM(0, 0, 0, 0, 32'h0, 32'h0);
    setM(1, 0, 0, 0, 32'h0, 32'h0);
    memIf.stall = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_grant", grant, 2'b00);
    checkOutput("rst_timeout", timeout, 1'b0);
    checkOutput("rst_mem_cyc", memIf.cyc, 1'b0);
    checkOutput("rst_mem_adr", memIf.adr, 32'h0);
    checkOutput("rst_m0_stall", m0If.stall, 1'b1);
    checkOutput("rst_m1_stall", m1If.stall, 1'b1);
    checkOutput("rst_m0_dats", m0If.dat_s, 32'h0);
    checkOutput("rst_ackcnt0", ackcnt0, 32'h0);
    @(negedge clk_i) rst_i = 1'b0;

    // 1: lone m0 4-beat read
    $display("[TB] test 1: m0 line read");
    chkM1Stall = 1;
    setM(0, 1, 1, 0, 32'h100, 32'h0);
    #1;
    checkOutput("t1_grant_pre", grant, 2'b00);
    checkOutput("t1_m0_stall_pre", m0If.stall, 1'b1);
    tick;
    checkOutput("t1_grant", grant, 2'b01);
    checkOutput("t1_mem_cyc", memIf.cyc, 1'b1);
    checkOutput("t1_mem_adr", memIf.adr, 32'h100);
    applyStimulus(0, 32'h100, 0, 4, -1, -1, rd);
    checkOutput("t1_last_rd", rd, 32'h1000010c);
    tick;
    checkOutput("t1_ackcnt0", ackcnt0, 32'd4);
    checkOutput("t1_idle", grant, 2'b00);
    chkM1Stall = 0;
    checkOutput("t1_m1_stall_held", m1StallViol, 0);

    // 2: simultaneous requests after reset, turnaround, round-robin
    $display("[TB] test 2: tie and round-robin");
    @(negedge clk_i) rst_i = 1'b1;
    @(negedge clk_i) rst_i = 1'b0;
    #1;
    setM(0, 1, 1, 0, 32'h100, 32'h0);
    setM(1, 1, 1, 0, 32'h2000, 32'h0);
    #1;
    checkOutput("t2_grant_pre", grant, 2'b00);
    tick;
    checkOutput("t2_first_m0", grant, 2'b01);
    checkOutput("t2_mem_adr", memIf.adr, 32'h100);
    checkOutput("t2_m1_stall", m1If.stall, 1'b1);
    applyStimulus(0, 32'h100, 0, 2, -1, -1, rd);
    tick;
    checkOutput("t2_turnaround", grant, 2'b00);
    checkOutput("t2_turn_memcyc", memIf.cyc, 1'b0);
    tick;
    checkOutput("t2_then_m1", grant, 2'b10);
    applyStimulus(1, 32'h2000, 0, 1, -1, -1, rd);
    checkOutput("t2_m1_rd", rd, 32'h10002000);
    tick;
    checkOutput("t2_idle", grant, 2'b00);
    setM(0, 1, 1, 0, 32'h100, 32'h0);
    setM(1, 1, 1, 0, 32'h2000, 32'h0);
    tick;
    checkOutput("t2_rr_tie_m0", grant, 2'b01);
    applyStimulus(0, 32'h100, 0, 1, -1, -1, rd);
    tick;
    tick;
    checkOutput("t3_m1_grant", grant, 2'b10);
    checkOutput("t2_ackcnt0", ackcnt0, 32'd3);
    checkOutput("t2_ackcnt1", ackcnt1, 32'd1);

    // 3: m1 flush with m0 requesting mid-burst
    $display("[TB] test 3: m1 flush, m0 interrupts");
    applyStimulus(1, 32'h2000, 1, 4, -1, 1, rd);
    checkOutput("t3_m0_stalled", m0If.stall, 1'b1);
    tick;
    checkOutput("t3_turnaround", grant, 2'b00);
    checkOutput("t3_ackcnt1", ackcnt1, 32'd5);
    tick;
    checkOutput("t3_m0_grant", grant, 2'b01);
    checkOutput("t3_m0_adr", memIf.adr, 32'h140);
    checkOutput("t3_adr_clean", adrViol, 0);
    checkOutput("t3_last_wr", lastWr, 32'hdeadbef2);
    applyStimulus(0, 32'h140, 0, 1, -1, -1, rd);
    tick;

    // 4: slave stalls 3 cycles mid-burst
    $display("[TB] test 4: stall during m0 burst");
    setM(0, 1, 1, 0, 32'h180, 32'h0);
    tick;
    checkOutput("t4_grant", grant, 2'b01);
    beatsBefore = slaveBeats;
    applyStimulus(0, 32'h180, 0, 4, 1, -1, rd);
    checkOutput("t4_last_rd", rd, 32'h1000018c);
    tick;
    checkOutput("t4_beats", slaveBeats - beatsBefore, 4);
    checkOutput("t4_no_timeout", timeoutCnt, 0);
    checkOutput("t4_ackcnt0", ackcnt0, 32'd8);

    // 5: slave never acks, watchdog abort after 8 granted cycles
    $display("[TB] test 5: watchdog abort");
    slaveAckEn = 0;
    setM(0, 1, 1, 0, 32'h300, 32'h0);
    tick;
    checkOutput("t5_grant", grant, 2'b01);
    checkOutput("t5_no_pulse_1", timeout, 1'b0);
    setM(0, 1, 0, 0, 32'h300, 32'h0);
    for (int k = 2; k <= 7; k++) begin
      tick;
      checkOutput("t5_no_pulse", timeout, 1'b0);
    end
    tick;
    checkOutput("t5_pulse", timeout, 1'b1);
    checkOutput("t5_cyc_at_pulse", memIf.cyc, 1'b1);
    tick;
    checkOutput("t5_pulse_end", timeout, 1'b0);
    checkOutput("t5_abort_cyc", memIf.cyc, 1'b0);
    checkOutput("t5_abort_stall", m0If.stall, 1'b1);
    injectAck = 1;
    tick;
    injectAck = 0;
    checkOutput("t5_late_ack_drop", m0If.ack, 1'b0);
    setM(1, 1, 1, 0, 32'h2000, 32'h0);
    tick;
    checkOutput("t5_late_ack_uncounted", ackcnt0, 32'd8);
    checkOutput("t5_abort_hold", memIf.cyc, 1'b0);
    checkOutput("t5_m1_wait_stall", m1If.stall, 1'b1);
    setM(0, 0, 0, 0, 32'h0, 32'h0);
    slaveAckEn = 1;
    tick;
    checkOutput("t5_idle", grant, 2'b00);
    tick;
    checkOutput("t5_m1_grant", grant, 2'b10);
    applyStimulus(1, 32'h2000, 0, 2, -1, -1, rd);
    tick;
    checkOutput("t5_ackcnt1", ackcnt1, 32'd7);
    checkOutput("t5_one_pulse", timeoutCnt, 1);

    // 6: reset in the middle of a burst
    $display("[TB] test 6: reset mid-burst");
    setM(0, 1, 1, 0, 32'h400, 32'h0);
    tick;
    checkOutput("t6_grant", grant, 2'b01);
    setM(0, 1, 1, 0, 32'h404, 32'h0);
    tick;
    rst_i = 1'b1;
    #1;
    checkOutput("t6_rst_grant", grant, 2'b00);
    checkOutput("t6_rst_memcyc", memIf.cyc, 1'b0);
    checkOutput("t6_rst_ackcnt0", ackcnt0, 32'h0);
    checkOutput("t6_rst_ackcnt1", ackcnt1, 32'h0);
    checkOutput("t6_rst_m0_stall", m0If.stall, 1'b1);
    setM(0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk_i) rst_i = 1'b0;
    setM(1, 1, 1, 0, 32'h2000, 32'h0);
    #1;
    checkOutput("t6_grant_pre", grant, 2'b00);
    tick;
    checkOutput("t6_m1_grant", grant, 2'b10);
    applyStimulus(1, 32'h2000, 0, 1, -1, -1, rd);
    tick;
    checkOutput("t6_ackcnt1", ackcnt1, 32'd1);
    checkOutput("t6_ackcnt0", ackcnt0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
